// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/response bus between the load/store unit and memory
interface load_store_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store stage with byte-lane requests and core stall
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word accesses, adds o_misaligned)
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_stall,
  output logic        o_bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic        o_misaligned,
`endif
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic        r_mis;
  logic [31:0] r_rdata;

  logic        w_start;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_start   = i_mem_read | i_mem_write;
  // Counter holds the number of REQ/WAIT cycles already spent; this is the last allowed one.
  assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((i_funct3[1:0] == 2'b01) & i_alu_result[0]) |
                      (i_funct3[1] & (i_alu_result[1:0] != 2'b00));
  assign o_misaligned = (r_state == S_DONE) & r_mis;
`else
  assign w_misalign = 1'b0;
`endif

  // Store lane enables and lane-replicated data; funct3[2] does not matter for stores.
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = i_write_data;
    case (i_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << i_alu_result[1:0];
        w_wdata = {4{i_write_data[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << {i_alu_result[1], 1'b0};
        w_wdata = {2{i_write_data[15:0]}};
      end
      default: ;
    endcase
    if (!i_mem_write) begin
      w_wstrb = 4'b0000;
    end
  end

  // Load formatting from the latched address offset and funct3.
  always_comb begin
    w_byte = mem.mem_rdata[{r_addr_lo, 3'b000} +: 8];
    w_half = mem.mem_rdata[{r_addr_lo[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'b0, w_byte};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = mem.mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and decoded outputs; Stall is combinational only while IDLE.
  always_comb begin
    w_next            = r_state;
    o_stall           = 1'b0;
    mem.mem_req_valid = 1'b0;
    o_bus_err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall = reset & w_start;
        if (w_start) begin
          w_next = w_misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        o_stall           = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) begin
          w_next = r_we ? S_DONE : S_WAIT;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (mem.mem_rsp_valid || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_bus_err = r_err;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, timeout counting and load-data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr    <= 32'b0;
      r_addr_lo <= 2'b0;
      r_funct3  <= 3'b0;
      r_we      <= 1'b0;
      r_wstrb   <= 4'b0;
      r_wdata   <= 32'b0;
      r_cnt     <= 8'b0;
      r_err     <= 1'b0;
      r_mis     <= 1'b0;
      r_rdata   <= 32'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr    <= {i_alu_result[31:2], 2'b00};
            r_addr_lo <= i_alu_result[1:0];
            r_funct3  <= i_funct3;
            r_we      <= i_mem_write;
            r_wstrb   <= w_wstrb;
            r_wdata   <= w_wdata;
            r_cnt     <= 8'b0;
            r_err     <= 1'b0;
            r_mis     <= w_misalign;
            if (w_misalign) begin
              r_rdata <= 32'b0;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (!mem.mem_req_ready && w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (mem.mem_rsp_valid) begin
            r_rdata <= w_load;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_addr  = r_addr;
  assign mem.mem_we    = r_we;
  assign mem.mem_wstrb = r_wstrb;
  assign mem.mem_wdata = r_wdata;
  assign o_read_data   = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, write_data;
  logic [31:0] read_data;
  logic        stall, bus_err;
  logic        t_read;
  logic [31:0] t_addr;
  logic [31:0] t_read_data;
  logic        t_stall, t_bus_err;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned, t_misaligned;
`endif

  load_store_unit_if mif ();
  load_store_unit_if tif ();

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
    .i_alu_result(alu_result), .i_write_data(write_data),
    .o_read_data(read_data), .o_stall(stall), .o_bus_err(bus_err),
`ifdef MISALIGN_TRAP_EN
    .o_misaligned(misaligned),
`endif
    .mem(mif)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) tdut (
    .clk(clk), .reset(reset),
    .i_mem_read(t_read), .i_mem_write(1'b0), .i_funct3(3'b010),
    .i_alu_result(t_addr), .i_write_data(32'h0),
    .o_read_data(t_read_data), .o_stall(t_stall), .o_bus_err(t_bus_err),
`ifdef MISALIGN_TRAP_EN
    .o_misaligned(t_misaligned),
`endif
    .mem(tif)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rsp;
    int          dly;
    logic        upd;
    logic [31:0] exp_rd;
    logic        mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    int          exp_req;
    int          exp_stalls;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  vec_t        vecs[$];
  logic [31:0] model_rd = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rsp,
                              input int dly, input logic upd, input logic [31:0] exp_rd, input logic mis,
                              input logic [31:0] ea, input logic [3:0] ews, input logic [31:0] ewd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rsp = rsp;
    v.dly = dly; v.upd = upd; v.exp_rd = exp_rd; v.mis = mis;
    v.exp_addr = ea; v.exp_wstrb = ews; v.exp_wdata = ewd;
    v.exp_req    = mis ? 0 : dly + 1;
    v.exp_stalls = mis ? 1 : (wr ? 1 : 2) + dly + 1;
    return v;
  endfunction

  // Scoreboard: at each commit cycle (access pending, Stall low) pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && (mem_read | mem_write) && !stall) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_commit actual=commit required=none");
      end else begin
        e = sb_q.pop_front();
        check32("read_data", read_data, e.rd);
        check32("bus_err_commit", 32'(bus_err), 32'h0);
`ifdef MISALIGN_TRAP_EN
        check32("misaligned_commit", 32'(misaligned), 32'(e.mis));
`endif
      end
    end else if (reset === 1'b1) begin
      check32("bus_err_quiet", 32'(bus_err), 32'h0);
`ifdef MISALIGN_TRAP_EN
      check32("misaligned_quiet", 32'(misaligned), 32'h0);
`endif
    end
  end

  task automatic run_access(input vec_t v);
    int   stalls, reqs;
    bit   acc, done;
    exp_t e;
    if (v.upd) model_rd = v.exp_rd;
    e.rd = model_rd; e.mis = v.mis;
    sb_q.push_back(e);
    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; alu_result = v.addr; write_data = v.wd;
    stalls = 0; reqs = 0; acc = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
      end else begin
        stalls++;
        mif.mem_req_ready = 1'b0;
        mif.mem_rsp_valid = 1'b0;
        if (mif.mem_req_valid) begin
          reqs++;
          check32("mem_addr", mif.mem_addr, v.exp_addr);
          check32("mem_we", 32'(mif.mem_we), 32'(v.wr));
          check32("mem_wstrb", 32'(mif.mem_wstrb), 32'(v.exp_wstrb));
          if (v.wr) check32("mem_wdata", mif.mem_wdata, v.exp_wdata);
          if (reqs > v.dly) begin
            mif.mem_req_ready = 1'b1;
            acc = 1;
          end
        end else if (acc) begin
          mif.mem_rsp_valid = 1'b1;
          mif.mem_rdata     = v.rsp;
        end
      end
    end
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    check32("commit_seen", 32'(done), 32'h1);
    check32("stall_cycles", 32'(stalls), 32'(v.exp_stalls));
    check32("req_cycles", 32'(reqs), 32'(v.exp_req));
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_stall, n_req, n_err;
    bit committed;

    vecs.push_back(mk(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 0, 1, 32'hFFFFFF80, 0, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 0, 1, 32'h00000080, 0, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 5, 0, 32'h0, 0, 32'h100, 4'hC, 32'hABCDABCD));
    vecs.push_back(mk(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0, 0, 32'h0, 0, 32'h200, 4'h2, 32'hA5A5A5A5));
    vecs.push_back(mk(1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 0, 1, 32'hFFFF8001, 0, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 1, 1, 32'h00008001, 0, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h100, 32'h0, 32'h80017FFF, 0, 1, 32'h00007FFF, 0, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h101, 32'h0, 32'h80FF7F01, 0, 1, 32'h0000007F, 0, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h10C, 32'h0, 32'h11223344, 0, 1, 32'h11223344, 0, 32'h10C, 4'h0, 32'h0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h300, 32'h000055AA, 32'h0, 1, 0, 32'h0, 0, 32'h300, 4'hF, 32'h000055AA));
    vecs.push_back(mk(1, 0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 2, 1, 32'h0BADF00D, 0, 32'h104, 4'h0, 32'h0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 1, 3'b010, 32'h101, 32'hCAFEF00D, 32'h0, 0, 1, 32'h0, 1, 32'h0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h104, 32'h0, 32'h5A5A1234, 0, 1, 32'h5A5A1234, 0, 32'h104, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h103, 32'h0, 32'h80FF7F01, 0, 1, 32'h0, 1, 32'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h101, 32'h1234ABCD, 32'h0, 0, 1, 32'h0, 1, 32'h0, 4'h0, 32'h0));
`else
    vecs.push_back(mk(0, 1, 3'b010, 32'h101, 32'hCAFEF00D, 32'h0, 0, 0, 32'h0, 0, 32'h100, 4'hF, 32'hCAFEF00D));
    vecs.push_back(mk(1, 0, 3'b101, 32'h103, 32'h0, 32'h80FF7F01, 0, 1, 32'h000080FF, 0, 32'h100, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h103, 32'h1234ABCD, 32'h0, 0, 0, 32'h0, 0, 32'h100, 4'hC, 32'hABCDABCD));
`endif

    // Reset state, with a load request pending to show Stall is forced low.
    reset = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h0; write_data = 32'h0;
    t_read = 1'b0; t_addr = 32'h0;
    mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0; mif.mem_rdata = 32'h0;
    tif.mem_req_ready = 1'b0; tif.mem_rsp_valid = 1'b0; tif.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check32("rst_stall", 32'(stall), 32'h0);
    check32("rst_req_valid", 32'(mif.mem_req_valid), 32'h0);
    check32("rst_we", 32'(mif.mem_we), 32'h0);
    check32("rst_wstrb", 32'(mif.mem_wstrb), 32'h0);
    check32("rst_addr", mif.mem_addr, 32'h0);
    check32("rst_wdata", mif.mem_wdata, 32'h0);
    check32("rst_read_data", read_data, 32'h0);
    check32("rst_bus_err", 32'(bus_err), 32'h0);
`ifdef MISALIGN_TRAP_EN
    check32("rst_misaligned", 32'(misaligned), 32'h0);
`endif
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) run_access(vecs[i]);

    // Timeout instance: one good load, then a load whose request is never accepted.
    @(posedge clk); #1;
    t_read = 1'b1; t_addr = 32'h40;
    @(negedge clk);
    @(negedge clk); tif.mem_req_ready = 1'b1;
    @(negedge clk); tif.mem_req_ready = 1'b0; tif.mem_rsp_valid = 1'b1; tif.mem_rdata = 32'h12345678;
    @(negedge clk); tif.mem_rsp_valid = 1'b0;
    check32("to_ok_stall", 32'(t_stall), 32'h0);
    check32("to_ok_read_data", t_read_data, 32'h12345678);
    check32("to_ok_bus_err", 32'(t_bus_err), 32'h0);
    @(posedge clk); #1;
    t_read = 1'b0;
    @(posedge clk); #1;
    t_read = 1'b1; t_addr = 32'h44;
    n_stall = 0; n_req = 0; n_err = 0; committed = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (t_stall) n_stall++;
      if (tif.mem_req_valid) n_req++;
      if (t_bus_err) n_err++;
      if (t_read && !t_stall) begin
        committed = 1;
        check32("to_read_data", t_read_data, 32'h0);
        check32("to_bus_err_commit", 32'(t_bus_err), 32'h1);
        t_read = 1'b0;
      end
    end
    check32("to_committed", 32'(committed), 32'h1);
    check32("to_req_cycles", 32'(n_req), 32'd4);
    check32("to_stall_cycles", 32'(n_stall), 32'd5);
    check32("to_bus_err_pulses", 32'(n_err), 32'd1);
    check32("to_idle_req_valid", 32'(tif.mem_req_valid), 32'h0);

    // Reset asserted mid-WAIT, then a stray response after release.
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h180;
    @(negedge clk);
    @(negedge clk);
    check32("rw_req_valid", 32'(mif.mem_req_valid), 32'h1);
    mif.mem_req_ready = 1'b1;
    @(negedge clk);
    mif.mem_req_ready = 1'b0;
    check32("rw_wait_stall", 32'(stall), 32'h1);
    #2 reset = 1'b0;
    #1;
    check32("rw_rst_stall", 32'(stall), 32'h0);
    check32("rw_rst_req_valid", 32'(mif.mem_req_valid), 32'h0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    mif.mem_rsp_valid = 1'b1; mif.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mif.mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check32("rw_after_stall", 32'(stall), 32'h0);
      check32("rw_after_req_valid", 32'(mif.mem_req_valid), 32'h0);
      check32("rw_after_read_data", read_data, 32'h0);
    end

    check32("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage between the single-cycle datapath's ALUResult/WriteData outputs and a handshaked data memory; it returns formatted load data on ReadData. It turns MemRead/MemWrite plus funct3 into byte-lane memory requests (lb/lh/lw/lbu/lhu, sb/sh/sw). While a request is in flight it freezes the core through Stall, which holds the PC register and the register-file write.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles in REQ+WAIT before the access is aborted with BusErr (8-bit counter, 1..255).

- clk  in  1  rising-edge clock, shared with the core
- reset  in  1  asynchronous, active-low; asserted (0) forces IDLE immediately
- MemRead  in  1  load instruction in current cycle
- MemWrite  in  1  store instruction in current cycle
- Funct3  in  3  Instr[14:12], access size/signedness
- ALUResult  in  32  byte address
- WriteData  in  32  store data (rs2)
- ReadData  out  32  formatted load data to result mux
- Stall  out  1  core must not advance PC or write rd
- BusErr  out  1  one-cycle pulse: access timed out
- Misaligned  out  1  one-cycle pulse: misaligned access (only with MISALIGN_TRAP_EN)
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word address ({addr[31:2],2'b00})
- mem_we  out  1  1 = write
- mem_wstrb  out  4  byte-lane write enables
- mem_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  read data valid
- mem_rdata  in  32  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if MemWrite|MemRead, latch address, data, Funct3, and direction, then go to REQ. MemWrite wins if both are set. Stall = MemRead|MemWrite.
- REQ: mem_req_valid=1. Address, we, wstrb, and wdata are held stable until mem_req_ready. On acceptance a store goes to DONE and a load goes to WAIT. Stall=1.
- WAIT: on mem_rsp_valid, capture mem_rdata and go to DONE. Stall=1. mem_rsp_valid in any other state is ignored.
- DONE: Stall=0 and ReadData is valid, so the core commits on this edge. Next state is IDLE unconditionally.
- Timeout counter: cleared on entry to REQ and incremented in REQ/WAIT. When it reaches TIMEOUT_CYCLES, the FSM goes to DONE, BusErr pulses in DONE, and ReadData=0.
- Store lanes:
  - sb: wstrb=0001<<addr[1:0], wdata={4{rs2[7:0]}}
  - sh: wstrb=0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}
  - sw: wstrb=1111
- Load format: byte/half selected by addr[1:0]. 000 lb sign-extend, 001 lh sign-extend, 010 lw, 100 lbu zero-extend, 101 lhu zero-extend.
- Funct3 011/110/111 are treated as word accesses.
- Loads drive mem_wstrb=0000 and mem_we=0.

## Timing
- Reset values: state IDLE, mem_req_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, ReadData=0, BusErr=0, Misaligned=0. Stall is forced to 0 while reset is asserted.
- Reset mid-operation: the request is dropped and mem_req_valid falls asynchronously. Any late mem_rsp_valid is ignored.
- Minimum latency with ready=1 and the response one cycle after acceptance:
  - load: 4 cycles (IDLE, REQ, WAIT, DONE)
  - store: 3 cycles (IDLE, REQ, DONE)
- Stall is combinational in IDLE only. In all other states it is decoded from registered state.
- ReadData is registered and holds its value until the next load's DONE.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned access in IDLE (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0) issues no memory request.
  - The FSM goes directly to DONE. Misaligned pulses there, ReadData=0, and no write occurs.
- MISALIGN_TRAP_EN undefined:
  - There is no Misaligned port; it is tied off and absent.
  - Word accesses ignore addr[1:0].
  - Half accesses ignore addr[0] and use the addr[1] lane.

## Test plan
- lw: addr 0x100, ready=1, rdata=0xDEADBEEF one cycle after acceptance -> Stall high 3 cycles, ReadData=0xDEADBEEF in DONE, mem_addr=0x100.
- lb/lbu: addr 0x103, rdata=0x80FF7F01 -> lb ReadData=0xFFFFFF80, lbu ReadData=0x00000080.
- sh: addr 0x102, WriteData=0x1234ABCD, ready delayed 5 cycles -> mem_wstrb=1100, mem_wdata=0xABCDABCD held stable for all 6 REQ cycles, Stall drops in DONE.
- Timeout: TIMEOUT_CYCLES=4, ready never asserts -> BusErr pulses exactly once after 4 REQ cycles, ReadData=0, FSM back in IDLE.
- Reset mid-WAIT: assert reset -> mem_req_valid=0 and Stall=0 immediately; after release a rsp_valid pulse is ignored and the FSM stays in IDLE.
- MISALIGN_TRAP_EN: sw to 0x101 -> no mem_req_valid, Misaligned pulses in cycle 2, no write. Without the macro -> write to 0x100 with wstrb=1111.
